mux_scan: RTL

MUX_SCAN -- requirements
Module: mux_scan

---
 rtl/mux_scan.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mux_scan.sv
// mux_scan: registered N-to-1 channel selector with manual select and a
// dwell-timed auto-scan. Every output comes straight from a flop.
module mux_scan #(
    parameter int N     = 8,
    parameter int W     = 8,
    parameter int DWELL = 4,
    localparam int SW   = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  i,
    input  logic [SW-1:0]   s,
    input  logic            mode,
    input  logic            en,
    output logic [W-1:0]    x,
    output logic [SW-1:0]   ch,
    output logic            valid,
    output logic            wrap,
    output logic            err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAN  = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic [7:0]    DWELL_LAST = 8'(DWELL - 1);
    localparam logic [SW-1:0] CHAN_LAST  = SW'(N - 1);

    state_t          state_r, state_s;
    logic [7:0]      dwell_r, dwell_s;
    logic [SW-1:0]   chan_r,  chan_s;
    logic [W-1:0]    x_r,     x_s;
    logic [SW-1:0]   ch_r,    ch_s;
    logic            valid_r, valid_s;
    logic            wrap_r,  wrap_s;
    logic            err_r,   err_s;
    // Set when the scan steps N-1 -> 0 so the wrap pulse lands on the
    // first sample of channel 0 rather than on the stepping edge.
    logic            pend_r,  pend_s;
    logic            s_ok_s;

    // Channel picker written as a compare loop so that selects beyond N-1
    // (non-power-of-2 N) never index outside the packed bus.
    function automatic logic [W-1:0] pick(input logic [N*W-1:0] d,
                                          input logic [SW-1:0]  k);
        logic [W-1:0] r;
        r = '0;
        for (int c = 0; c < N; c++) begin
            if (k == SW'(c)) begin
                r = d[c*W +: W];
            end
        end
        return r;
    endfunction

    assign s_ok_s = ({{(32-SW){1'b0}}, s} < 32'(N));

    // Next-state and next-output logic; with en low everything holds and
    // the two pulse outputs fall to 0.
    always_comb begin
        state_s = state_r;
        dwell_s = dwell_r;
        chan_s  = chan_r;
        x_s     = x_r;
        ch_s    = ch_r;
        err_s   = err_r;
        pend_s  = pend_r;
        valid_s = 1'b0;
        wrap_s  = 1'b0;
        if (en) begin
            if ((state_r == SCAN) && mode) begin
                // Live tracking of the current scan channel.
                x_s     = pick(i, chan_r);
                ch_s    = chan_r;
                valid_s = 1'b1;
                err_s   = 1'b0;
                wrap_s  = pend_r;
                pend_s  = 1'b0;
                if (dwell_r == DWELL_LAST) begin
                    dwell_s = 8'd0;
                    if (chan_r == CHAN_LAST) begin
                        chan_s = {SW{1'b0}};
                        pend_s = 1'b1;
                    end else begin
                        chan_s = chan_r + SW'(1);
                    end
                end else begin
                    dwell_s = dwell_r + 8'd1;
                end
            end else if (mode) begin
                // Entry into SCAN from IDLE or MAN: latch start channel.
                state_s = SCAN;
                chan_s  = s_ok_s ? s : {SW{1'b0}};
                dwell_s = 8'd0;
                pend_s  = 1'b0;
            end else begin
                // Manual select; a mode drop in SCAN lands here on the same
                // edge, beating any pending dwell step or wrap.
                state_s = MAN;
                pend_s  = 1'b0;
                if (s_ok_s) begin
                    x_s     = pick(i, s);
                    ch_s    = s;
                    valid_s = 1'b1;
                    err_s   = 1'b0;
                end else begin
                    err_s   = 1'b1;
                end
            end
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            dwell_r <= 8'd0;
            chan_r  <= {SW{1'b0}};
            x_r     <= {W{1'b0}};
            ch_r    <= {SW{1'b0}};
            valid_r <= 1'b0;
            wrap_r  <= 1'b0;
            err_r   <= 1'b0;
            pend_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            dwell_r <= dwell_s;
            chan_r  <= chan_s;
            x_r     <= x_s;
            ch_r    <= ch_s;
            valid_r <= valid_s;
            wrap_r  <= wrap_s;
            err_r   <= err_s;
            pend_r  <= pend_s;
        end
    end

    assign x     = x_r;
    assign ch    = ch_r;
    assign valid = valid_r;
    assign wrap  = wrap_r;
    assign err   = err_r;

endmodule
